// File: rtl/pixel_array_pkg.sv
// Shared widths and default constants for the four-pixel array.
package pixel_array_pkg;
    localparam int DATA_W = 8;
    localparam int Q_W    = 16;
    localparam int R_W    = 8;

    localparam logic [7:0] DV1_DEF       = 8'd1;
    localparam logic [7:0] DV2_DEF       = 8'd2;
    localparam logic [7:0] DV3_DEF       = 8'd3;
    localparam logic [7:0] DV4_DEF       = 8'd4;
    localparam logic [7:0] RAMP_STEP_DEF = 8'd64;

    function automatic logic [Q_W-1:0] q_sat_add(input logic [Q_W-1:0] q, input logic [7:0] dv);
        logic [Q_W:0] sum;
        sum = {1'b0, q} + {{(Q_W-7){1'b0}}, dv};
        return sum[Q_W] ? {Q_W{1'b1}} : sum[Q_W-1:0];
    endfunction
endpackage

// File: rtl/pixel_array_sensor.sv
// Single pixel: charge integration, single-slope ramp compare and code capture.
module pixel_sensor
    import pixel_array_pkg::*;
#(
    parameter logic [7:0] DV        = DV1_DEF,
    parameter logic [7:0] RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              expose_en,
    input  logic              erase_en,
    input  logic              ramp,
    input  logic              read,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] d
);
    logic [Q_W-1:0] q;
    logic [R_W-1:0] r;
    logic           t;
    logic [R_W-1:0] r_next;
    logic [Q_W-1:0] ramp_lvl;

    // 255*255 fits in 16 bits, so the product never overflows
    assign r_next   = (r == {R_W{1'b1}}) ? r : r + 1'b1;
    assign ramp_lvl = Q_W'(r_next) * Q_W'(RAMP_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
            r <= '0;
            t <= 1'b0;
            d <= '0;
        end else begin
            if (erase_en)
                q <= '0;
            else if (expose_en)
                q <= q_sat_add(q, DV);

            if (!ramp) begin
                r <= '0;
                t <= 1'b0;
            end else if (!t) begin
                r <= r_next;
                t <= (ramp_lvl >= q);
                if (!read)
                    d <= bus_in;
            end

            // erase wins over a trip decided in the same cycle
            if (erase_en)
                t <= 1'b0;
        end
    end
endmodule

// File: rtl/pixel_array.sv
// Four-pixel array with paired tristate readout on per-pixel data buses.
module pixel_array
    import pixel_array_pkg::*;
#(
    parameter logic [7:0] DV1       = DV1_DEF,
    parameter logic [7:0] DV2       = DV2_DEF,
    parameter logic [7:0] DV3       = DV3_DEF,
    parameter logic [7:0] DV4       = DV4_DEF,
    parameter logic [7:0] RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             anaBias1,
    input  logic             anaRamp,
    input  logic             anaReset,
    input  logic             erase,
    input  logic             expose,
    input  logic             read12,
    input  logic             read34,
    inout  wire [DATA_W-1:0] pixData1,
    inout  wire [DATA_W-1:0] pixData2,
    inout  wire [DATA_W-1:0] pixData3,
    inout  wire [DATA_W-1:0] pixData4
);
    localparam logic [3:0][7:0] DV_TAB = {DV4, DV3, DV2, DV1};

    logic [3:0][DATA_W-1:0] bus_in;
    logic [3:0][DATA_W-1:0] d;
    logic [3:0][DATA_W-1:0] drv;
    logic [3:0]             rd;

    assign rd     = {read34, read34, read12, read12};
    assign bus_in = {pixData4, pixData3, pixData2, pixData1};

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_pix
            pixel_sensor #(.DV(DV_TAB[k]), .RAMP_STEP(RAMP_STEP)) u_pix (
                .clk       (clk),
                .reset     (reset),
                .expose_en (expose & anaBias1),
                .erase_en  (erase & anaReset),
                .ramp      (anaRamp),
                .read      (rd[k]),
                .bus_in    (bus_in[k]),
                .d         (d[k])
            );
            // stored code is not yet cleared while reset is held, so force zero
            assign drv[k] = reset ? '0 : d[k];
        end
    endgenerate

    assign pixData1 = read12 ? drv[0] : {DATA_W{1'bz}};
    assign pixData2 = read12 ? drv[1] : {DATA_W{1'bz}};
    assign pixData3 = read34 ? drv[2] : {DATA_W{1'bz}};
    assign pixData4 = read34 ? drv[3] : {DATA_W{1'bz}};
endmodule

// File: tb/tb_pixel_array.sv
// Directed bench for pixel_array: scenario table plus hand sequences for reset/erase/readout corners.
module tb_pixel_array;
    logic clk = 1'b0;
    logic reset, anaBias1, anaRamp, anaReset, erase, expose, read12, read34;
    logic drv12, drv34;
    logic [7:0] bus;
    wire  [7:0] pd1, pd2, pd3, pd4;
    wire  [7:0] ps1, ps2, ps3, ps4;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign pd1 = drv12 ? bus : 8'bz;
    assign pd2 = drv12 ? bus : 8'bz;
    assign pd3 = drv34 ? bus : 8'bz;
    assign pd4 = drv34 ? bus : 8'bz;
    assign ps1 = drv12 ? bus : 8'bz;
    assign ps2 = drv12 ? bus : 8'bz;
    assign ps3 = drv34 ? bus : 8'bz;
    assign ps4 = drv34 ? bus : 8'bz;

    pixel_array dut (
        .clk(clk), .reset(reset), .anaBias1(anaBias1), .anaRamp(anaRamp),
        .anaReset(anaReset), .erase(erase), .expose(expose),
        .read12(read12), .read34(read34),
        .pixData1(pd1), .pixData2(pd2), .pixData3(pd3), .pixData4(pd4)
    );

    pixel_array #(.DV4(8'd255)) dut_sat (
        .clk(clk), .reset(reset), .anaBias1(anaBias1), .anaRamp(anaRamp),
        .anaReset(anaReset), .erase(erase), .expose(expose),
        .read12(read12), .read34(read34),
        .pixData1(ps1), .pixData2(ps2), .pixData3(ps3), .pixData4(ps4)
    );

    typedef struct {
        int         er;
        int         ex;
        int         rp;
        logic [7:0] e1, e2, e3, e4, es;
    } scen_t;

    scen_t tab [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_scen(input int er, input int ex, input int rp);
        erase = 1'b1; anaReset = 1'b1;
        for (int i = 0; i < er; i++) tick();
        erase = 1'b0; anaReset = 1'b0;
        expose = 1'b1; anaBias1 = 1'b1;
        for (int i = 0; i < ex; i++) tick();
        expose = 1'b0; anaBias1 = 1'b0;
        anaRamp = 1'b1;
        for (int i = 0; i < rp; i++) begin
            bus = 8'(i);
            tick();
        end
        anaRamp = 1'b0;
        tick();
    endtask

    task automatic readout(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] es);
        drv12 = 1'b0; drv34 = 1'b0;
        read12 = 1'b1; read34 = 1'b1;
        #1;
        chk({tag, " d1"}, pd1, e1);
        chk({tag, " d2"}, pd2, e2);
        chk({tag, " d3"}, pd3, e3);
        chk({tag, " d4"}, pd4, e4);
        chk({tag, " sat d4"}, ps4, es);
        read12 = 1'b0; read34 = 1'b0;
        drv12 = 1'b1; drv34 = 1'b1;
        bus = 8'h50;
        #1;
        chk({tag, " hiz1"}, pd1, 8'h50);
        chk({tag, " hiz2"}, pd2, 8'h50);
        chk({tag, " hiz3"}, pd3, 8'h50);
        chk({tag, " hiz4"}, pd4, 8'h50);
    endtask

    initial begin
        tab[0] = '{2, 127, 10, 8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
        tab[1] = '{2,   0, 10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tab[2] = '{2,  64, 10, 8'd0, 8'd1, 8'd2, 8'd3, 8'd9};
        tab[3] = '{2, 258, 10, 8'd4, 8'd8, 8'd9, 8'd9, 8'd9};
        tab[4] = '{2, 300, 10, 8'd4, 8'd9, 8'd9, 8'd9, 8'd9};

        reset = 1'b1; anaBias1 = 1'b0; anaRamp = 1'b0; anaReset = 1'b0;
        erase = 1'b0; expose = 1'b0; read12 = 1'b0; read34 = 1'b0;
        drv12 = 1'b1; drv34 = 1'b1; bus = 8'hA5;
        tick(); tick();
        reset = 1'b0;
        readout("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        for (int s = 0; s < 5; s++) begin
            run_scen(tab[s].er, tab[s].ex, tab[s].rp);
            readout($sformatf("scen%0d", s), tab[s].e1, tab[s].e2, tab[s].e3, tab[s].e4, tab[s].es);
        end

        // pixels 1/2 under readout must not capture; 3/4 trip on Q=0
        read12 = 1'b1; drv12 = 1'b0; drv34 = 1'b1;
        erase = 1'b1; anaReset = 1'b1; tick(); erase = 1'b0; anaReset = 1'b0;
        anaRamp = 1'b1;
        bus = 8'h22; tick();
        bus = 8'h23; tick();
        anaRamp = 1'b0; tick();
        chk("rdlock live d1", pd1, 8'd4);
        chk("rdlock live d2", pd2, 8'd9);
        read12 = 1'b0; drv12 = 1'b1;
        readout("rdlock", 8'd4, 8'd9, 8'h22, 8'h22, 8'h22);

        // reset mid-conversion
        run_scen(2, 127, 0);
        anaRamp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus = 8'(i);
            tick();
        end
        reset = 1'b1; read12 = 1'b1; read34 = 1'b1; drv12 = 1'b0; drv34 = 1'b0;
        #1;
        chk("in-reset d1", pd1, 8'd0);
        chk("in-reset d3", pd3, 8'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post-reset d1", pd1, 8'd0);
        chk("post-reset d2", pd2, 8'd0);
        chk("post-reset d4", pd4, 8'd0);
        read12 = 1'b0; read34 = 1'b0; drv12 = 1'b1; drv34 = 1'b1;
        anaRamp = 1'b0; tick();
        anaRamp = 1'b1; bus = 8'h33; tick();
        anaRamp = 1'b0; tick();
        readout("q-cleared", 8'h33, 8'h33, 8'h33, 8'h33, 8'h33);

        // erase beats expose: Q stays 0 even on the DV=255 pixel
        erase = 1'b1; anaReset = 1'b1; expose = 1'b1; anaBias1 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        erase = 1'b0; anaReset = 1'b0; expose = 1'b0; anaBias1 = 1'b0;
        anaRamp = 1'b1;
        bus = 8'h44; tick();
        bus = 8'h45; tick();
        anaRamp = 1'b0; tick();
        readout("erase-prio", 8'h44, 8'h44, 8'h44, 8'h44, 8'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
